centroid_update_unit: RTL and testbench

- Downstream of each cluster PE's accumulate phase; implements its update step.
- Takes per-dimension coordinate sums and the point count, divides sequentially with one restoring divider shared across dimensions, and produces the new center.
- Compares the new center against the old center and reports local stability to the tree controller.

---
 rtl/centroid_update_unit.sv | 167 ++++++++++++++++
 tb/tb_centroid_update_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/centroid_update_unit.sv
// Divides per-dimension coordinate sums by the point count with one shared restoring divider,
// then flags stability against the old center. Define ROUND_NEAREST_EN for round-half-up division.
module centroid_update_unit #(
  parameter int DIM           = 3,
  parameter int DIM_SIZE      = 8,
  parameter int ACC_SIZE      = 18,
  parameter int CNT_SIZE      = 10,
  parameter int STABLE_THRESH = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM*ACC_SIZE-1:0]   acc_in,
  input  logic [CNT_SIZE-1:0]       count_in,
  input  logic [DIM*DIM_SIZE-1:0]   old_center,
  output logic                      busy,
  output logic                      done,
  output logic [DIM*DIM_SIZE-1:0]   new_center,
  output logic                      stable
);

`ifdef ROUND_NEAREST_EN
  localparam int DVD_W = ACC_SIZE + 1;
`else
  localparam int DVD_W = ACC_SIZE;
`endif
  localparam int REM_W  = DVD_W + 1;
  localparam int BIT_W  = $clog2(DVD_W);
  localparam int DIM_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int WIDE_W = DVD_W + DIM_SIZE;
  localparam logic [DIM_SIZE-1:0] MAX_Q  = {DIM_SIZE{1'b1}};
  localparam logic [DIM_SIZE-1:0] THRESH = DIM_SIZE'(STABLE_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CMP, S_DONE} state_t;

  state_t                    r_state;
  logic [DIM*ACC_SIZE-1:0]   r_acc;
  logic [CNT_SIZE-1:0]       r_cnt;
  logic [DIM*DIM_SIZE-1:0]   r_old;
  logic [DIM*DIM_SIZE-1:0]   r_work;
  logic [DIM_W-1:0]          r_dim;
  logic [BIT_W-1:0]          r_bit;
  logic [DVD_W-1:0]          r_rem;
  logic [DVD_W-2:0]          r_quo;
  logic                      r_busy;
  logic                      r_done;
  logic [DIM*DIM_SIZE-1:0]   r_new_center;
  logic                      r_stable;

  logic [ACC_SIZE-1:0]       w_acc_arr [DIM];
  logic [DIM-1:0]            w_in_thr;
  logic [ACC_SIZE-1:0]       w_acc_sel;
  logic [DVD_W-1:0]          w_dvd;
  logic [REM_W-1:0]          w_divisor;
  logic [REM_W-1:0]          w_rem_shift;
  logic                      w_ge;
  logic [DVD_W-1:0]          w_rem_sub;
  logic [DVD_W-1:0]          w_quo_full;
  logic [DIM_SIZE-1:0]       w_quo_sat;

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_dim
      logic [DIM_SIZE-1:0] w_work;
      logic [DIM_SIZE-1:0] w_old;
      logic [DIM_SIZE-1:0] w_diff;
      assign w_acc_arr[gi] = r_acc[gi*ACC_SIZE +: ACC_SIZE];
      assign w_work        = r_work[gi*DIM_SIZE +: DIM_SIZE];
      assign w_old         = r_old[gi*DIM_SIZE +: DIM_SIZE];
      assign w_diff        = (w_work >= w_old) ? (w_work - w_old) : (w_old - w_work);
      assign w_in_thr[gi]  = (w_diff <= THRESH);
    end
  endgenerate

  assign w_acc_sel = w_acc_arr[r_dim];

`ifdef ROUND_NEAREST_EN
  // Adding half the divisor before a floor divide yields round-half-up.
  assign w_dvd = DVD_W'(w_acc_sel) + DVD_W'(r_cnt >> 1);
`else
  assign w_dvd = w_acc_sel;
`endif

  // Remainder stays below the divisor, so the subtraction fits in DVD_W bits once w_ge holds.
  assign w_divisor   = REM_W'(r_cnt);
  assign w_rem_shift = {r_rem, w_dvd[r_bit]};
  assign w_ge        = (w_rem_shift >= w_divisor);
  assign w_rem_sub   = w_rem_shift[DVD_W-1:0] - w_divisor[DVD_W-1:0];
  assign w_quo_full  = {r_quo, w_ge};
  assign w_quo_sat   = (WIDE_W'(w_quo_full) > WIDE_W'(MAX_Q)) ? MAX_Q : w_quo_full[DIM_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_old        <= '0;
      r_work       <= '0;
      r_dim        <= '0;
      r_bit        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_new_center <= '0;
      r_stable     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc  <= acc_in;
            r_cnt  <= count_in;
            r_old  <= old_center;
            r_busy <= 1'b1;
            r_dim  <= '0;
            r_bit  <= BIT_W'(DVD_W - 1);
            r_rem  <= '0;
            r_quo  <= '0;
            if (count_in != '0) begin
              r_state <= S_DIV;
            end else begin
              // Empty cluster keeps its center.
              r_work  <= old_center;
              r_state <= S_CMP;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_shift[DVD_W-1:0];
          r_quo <= w_quo_full[DVD_W-2:0];
          if (r_bit == '0) begin
            r_work[r_dim*DIM_SIZE +: DIM_SIZE] <= w_quo_sat;
            r_rem <= '0;
            r_quo <= '0;
            r_bit <= BIT_W'(DVD_W - 1);
            if (r_dim == DIM_W'(DIM - 1)) begin
              r_state <= S_CMP;
            end else begin
              r_dim <= r_dim + 1'b1;
            end
          end else begin
            r_bit <= r_bit - 1'b1;
          end
        end
        S_CMP: begin
          r_new_center <= r_work;
          r_stable     <= &w_in_thr;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign new_center = r_new_center;
  assign stable     = r_stable;

endmodule

// File: tb/tb_centroid_update_unit.sv
// Directed bench for centroid_update_unit: an arithmetic model fills a scoreboard on each start,
// entries are popped on done; a second instance with threshold 1 covers the stability margin.
module tb_centroid_update_unit;
  localparam int DIM = 3;
  localparam int DS  = 8;
  localparam int AS  = 18;
  localparam int CS  = 10;
`ifdef ROUND_NEAREST_EN
  localparam int DW  = AS + 1;
  localparam bit RND = 1'b1;
`else
  localparam int DW  = AS;
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = DIM * DW + 2;

  typedef struct {
    logic [DIM*DS-1:0] center;
    logic              st0;
    logic              st1;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DIM*AS-1:0] acc_in = '0;
  logic [CS-1:0]     count_in = '0;
  logic [DIM*DS-1:0] old_center = '0;
  logic              busy, done, stable;
  logic [DIM*DS-1:0] new_center;
  logic              busy1, done1, stable1;
  logic [DIM*DS-1:0] new_center1;

  always #5 clk = ~clk;

  centroid_update_unit #(.DIM(DIM), .DIM_SIZE(DS), .ACC_SIZE(AS), .CNT_SIZE(CS), .STABLE_THRESH(0)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .count_in(count_in),
    .old_center(old_center), .busy(busy), .done(done), .new_center(new_center), .stable(stable)
  );

  centroid_update_unit #(.DIM(DIM), .DIM_SIZE(DS), .ACC_SIZE(AS), .CNT_SIZE(CS), .STABLE_THRESH(1)) dut_t1 (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .count_in(count_in),
    .old_center(old_center), .busy(busy1), .done(done1), .new_center(new_center1), .stable(stable1)
  );

  function automatic exp_t model(input logic [DIM*AS-1:0] acc, input logic [CS-1:0] cnt,
                                 input logic [DIM*DS-1:0] old);
    exp_t e;
    int q, o, d;
    e.st0 = 1'b1;
    e.st1 = 1'b1;
    e.lat = (cnt == 0) ? 2 : LAT;
    e.center = '0;
    for (int k = 0; k < DIM; k++) begin
      o = int'(old[k*DS +: DS]);
      if (cnt == 0) begin
        q = o;
      end else begin
        q = (int'(acc[k*AS +: AS]) + (RND ? int'(cnt) / 2 : 0)) / int'(cnt);
        if (q > (1 << DS) - 1) q = (1 << DS) - 1;
      end
      e.center[k*DS +: DS] = q[DS-1:0];
      d = (q > o) ? q - o : o - q;
      if (d > 0) e.st0 = 1'b0;
      if (d > 1) e.st1 = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation: start accepted at edge 0, cycle c sampled at the negedge after edge c-1.
  task automatic run_op(input string name, input logic [DIM*AS-1:0] acc, input logic [CS-1:0] cnt,
                        input logic [DIM*DS-1:0] old, input int restart_at, input int rst_at);
    exp_t e, got;
    bit   was_reset;
    int   last;
    @(negedge clk);
    acc_in = acc; count_in = cnt; old_center = old; start = 1'b1;
    e = model(acc, cnt, old);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_in = (DIM*AS)'({$urandom(), $urandom()});
    count_in = CS'($urandom());
    old_center = (DIM*DS)'($urandom());
    was_reset = 1'b0;
    last = (rst_at != 0) ? LAT + 6 : e.lat + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (was_reset) begin
        chk({name, ".post_rst_done"}, done, 1'b0);
        if (c == rst_at + 1) begin
          chk({name, ".rst_busy"}, busy, 1'b0);
          chk({name, ".rst_center"}, new_center, '0);
          chk({name, ".rst_stable"}, stable, 1'b0);
          rst = 1'b0;
        end
      end else begin
        chk({name, ".busy"}, busy, (c < e.lat));
        chk({name, ".done"}, done, (c == e.lat));
        if (done === 1'b1 && sb.size() > 0) begin
          got = sb.pop_front();
          chk({name, ".center"}, new_center, got.center);
          chk({name, ".stable"}, stable, got.st0);
          chk({name, ".center_t1"}, new_center1, got.center);
          chk({name, ".stable_t1"}, stable1, got.st1);
          $display("op %s: done at cycle %0d center=%h stable=%0b stable_t1=%0b",
                   name, c, new_center, stable, stable1);
        end
        if (c == e.lat + 1) chk({name, ".hold_center"}, new_center, e.center);
      end
      if (restart_at != 0 && c == restart_at) begin
        acc_in = {18'd5, 18'd5, 18'd5}; count_in = 10'd5; start = 1'b1;
      end
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        was_reset = 1'b1;
      end
    end
    if (rst_at != 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      $display("op %s: abandoned by reset at cycle %0d", name, rst_at);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.center", new_center, '0);
    chk("reset.stable", stable, 1'b0);
    rst = 1'b0;

    run_op("exact",  {18'd750, 18'd600, 18'd300}, 10'd3, {8'd250, 8'd200, 8'd100}, 0, 0);
    run_op("trunc",  {18'd31, 18'd20, 18'd10},    10'd4, {8'd7, 8'd5, 8'd2},       0, 0);
    run_op("empty",  {18'd77, 18'd88, 18'd99},    10'd0, {8'd9, 8'd9, 8'd9},       0, 0);
    run_op("sat",    {18'd255, 18'd0, 18'd1000},  10'd1, {8'd0, 8'd0, 8'd0},       0, 0);
    run_op("thr_in", {18'd32, 18'd20, 18'd8},     10'd4, {8'd7, 8'd5, 8'd3},       0, 0);
    run_op("thr_out",{18'd32, 18'd20, 18'd8},     10'd4, {8'd7, 8'd5, 8'd4},       0, 0);
    run_op("restart",{18'd750, 18'd600, 18'd300}, 10'd3, {8'd250, 8'd200, 8'd100}, 10, 0);
    run_op("rst",    {18'd750, 18'd600, 18'd300}, 10'd3, {8'd1, 8'd2, 8'd3},       0, 20);
    run_op("fresh",  {18'd31, 18'd20, 18'd10},    10'd4, {8'd7, 8'd5, 8'd2},       0, 0);
    for (int i = 0; i < 3; i++) begin
      run_op("rand", (DIM*AS)'({$urandom(), $urandom()}), CS'($urandom_range(1, 1023)),
             (DIM*DS)'($urandom()), 0, 0);
    end

    chk("scoreboard.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
